// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants and text/state byte-order helpers
package aes_pkg;

    localparam int AES128_NR = 10;

    localparam logic [1:0] MODE_ARK   = 2'd0;
    localparam logic [1:0] MODE_ROUND = 2'd1;
    localparam logic [1:0] MODE_FINAL = 2'd2;

    typedef enum logic {
        ST_IDLE,
        ST_FETCH
    } ctrl_state_e;

    // Transpose of the 4x4 byte matrix: state byte 4i+j takes text byte 4j+i.
    function automatic logic [127:0] text_to_state(input logic [127:0] t);
        logic [127:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s[8*(15-(4*i+j)) +: 8] = t[8*(15-(4*j+i)) +: 8];
            end
        end
        return s;
    endfunction

    // The transpose is its own inverse.
    function automatic logic [127:0] state_to_text(input logic [127:0] s);
        return text_to_state(s);
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 sequencer: state register, round counter, key fetch
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = AES128_NR,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [127:0]     plaintext,
    output logic             busy,
    output logic             done,
    output logic [127:0]     ciphertext,
    output logic             rk_req,
    output logic [IDX_W-1:0] rk_index,
    input  logic             rk_ack,
    input  logic [127:0]     rk_data,
    output logic [127:0]     dp_state,
    output logic [127:0]     dp_key,
    output logic [1:0]       dp_mode,
    input  logic [127:0]     dp_result
);

    localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(NR);

    ctrl_state_e      fsm;
    ctrl_state_e      fsm_next;
    logic [IDX_W-1:0] round;
    logic [127:0]     state_reg;
    logic             load;
    logic             advance;
    logic             finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= ST_IDLE;
            round      <= '0;
            state_reg  <= '0;
            ciphertext <= '0;
            done       <= 1'b0;
        end else begin
            fsm  <= fsm_next;
            done <= finish;
            if (load) begin
                state_reg <= text_to_state(plaintext);
                round     <= '0;
            end else if (advance) begin
                state_reg <= dp_result;
                round     <= round + 1'b1;
            end
            if (finish) begin
                ciphertext <= state_to_text(dp_result);
            end
        end
    end

    // The last key returns the finished block straight to text order; state_reg is left as is.
    always_comb begin
        fsm_next = fsm;
        load     = 1'b0;
        advance  = 1'b0;
        finish   = 1'b0;
        dp_mode  = MODE_ARK;
        case (fsm)
            ST_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    fsm_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (round == '0) begin
                    dp_mode = MODE_ARK;
                end else if (round == LAST_ROUND) begin
                    dp_mode = MODE_FINAL;
                end else begin
                    dp_mode = MODE_ROUND;
                end
                if (rk_ack) begin
                    if (round == LAST_ROUND) begin
                        finish   = 1'b1;
                        fsm_next = ST_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: fsm_next = ST_IDLE;
        endcase
    end

    assign busy     = (fsm == ST_FETCH);
    assign rk_req   = busy;
    assign rk_index = round;
    assign dp_state = state_reg;
    assign dp_key   = rk_data;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - randomized self-checking bench for aes_round_ctrl
module tb_aes_round_ctrl;

    localparam int NR = 10;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] plaintext;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;
    logic         rk_req;
    logic [3:0]   rk_index;
    logic         rk_ack;
    logic [127:0] rk_data;
    logic [127:0] dp_state;
    logic [127:0] dp_key;
    logic [1:0]   dp_mode;
    logic [127:0] dp_result;

    aes_round_ctrl #(.NR(NR), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .plaintext(plaintext),
        .busy(busy), .done(done), .ciphertext(ciphertext),
        .rk_req(rk_req), .rk_index(rk_index), .rk_ack(rk_ack), .rk_data(rk_data),
        .dp_state(dp_state), .dp_key(dp_key), .dp_mode(dp_mode), .dp_result(dp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_done = 0;
    int n_req_ack = 0;
    int idx_q[$];
    int mode_q[$];

    logic [7:0]   sbox [256];
    logic [127:0] rks [11];

    // Reference model: block in flight, keys consumed, state in text order
    bit           m_busy;
    bit           m_done;
    int           m_k;
    logic [127:0] m_st;
    logic [127:0] m_ct;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] v, inv, r1, r2, r3, r4;
        for (int x = 0; x < 256; x++) begin
            v   = 8'(x);
            inv = (v == 8'h00) ? 8'h00 : 8'h01;
            if (v != 8'h00) repeat (254) inv = gmul(inv, v);
            r1 = {inv[6:0], inv[7]};
            r2 = {r1[6:0], r1[7]};
            r3 = {r2[6:0], r2[7]};
            r4 = {r3[6:0], r3[7]};
            sbox[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] rk_of(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*(3-i) +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Text-order (column-major) round: kind 0 = key add only, 1 = full, 2 = final
    function automatic logic [127:0] m_round(input logic [127:0] s, input logic [127:0] k, input int kind);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = s[8*(15-i) +: 8];
        if (kind != 0) begin
            for (int i = 0; i < 16; i++) b[i] = sbox[b[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
            b = t;
        end
        if (kind == 1) begin
            for (int c = 0; c < 4; c++) begin
                a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
                b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[8*(15-i) +: 8] = b[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s;
        s = m_round(pt, rk_of(key, 0), 0);
        for (int r = 1; r < NR; r++) s = m_round(s, rk_of(key, r), 1);
        return m_round(s, rk_of(key, NR), 2);
    endfunction

    function automatic logic [127:0] to_state(input logic [127:0] t);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*(15-(4*(k%4)+k/4)) +: 8] = t[8*(15-k) +: 8];
        return o;
    endfunction

    // External round datapath, row-major state order; key arrives in text order
    function automatic logic [127:0] dp_func(input logic [127:0] s, input logic [127:0] k, input logic [1:0] mode);
        logic [7:0] a [4][4];
        logic [7:0] t [4][4];
        logic [7:0] x0, x1, x2, x3;
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) a[r][c] = s[8*(15-(4*r+c)) +: 8];
        if (mode != 2'd0) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = sbox[a[r][(c+r)%4]];
            a = t;
        end
        if (mode == 2'd1) begin
            for (int c = 0; c < 4; c++) begin
                x0 = a[0][c]; x1 = a[1][c]; x2 = a[2][c]; x3 = a[3][c];
                a[0][c] = gmul(x0, 8'h02) ^ gmul(x1, 8'h03) ^ x2 ^ x3;
                a[1][c] = x0 ^ gmul(x1, 8'h02) ^ gmul(x2, 8'h03) ^ x3;
                a[2][c] = x0 ^ x1 ^ gmul(x2, 8'h02) ^ gmul(x3, 8'h03);
                a[3][c] = gmul(x0, 8'h03) ^ x1 ^ x2 ^ gmul(x3, 8'h02);
            end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(15-(4*r+c)) +: 8] = a[r][c] ^ k[8*(15-(4*c+r)) +: 8];
        return o;
    endfunction

    always_comb dp_result = dp_func(dp_state, dp_key, dp_mode);

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_k = 0; m_st = '0; m_ct = '0;
    endtask

    // One clock: check DUT against model, drive inputs, advance model
    task automatic step(input bit st, input bit ack, input logic [127:0] pt, input logic [127:0] key);
        logic [1:0] em;
        @(negedge clk);
        cyc++;
        chk("busy", busy, m_busy);
        chk("rk_req", rk_req, m_busy);
        chk("done", done, m_done);
        chk("ciphertext", ciphertext, m_ct);
        chk("dp_key", dp_key, rk_data);
        if (m_busy) begin
            em = (m_k == 0) ? 2'd0 : (m_k == NR) ? 2'd2 : 2'd1;
            chk("rk_index", rk_index, m_k);
            chk("dp_mode", dp_mode, em);
            chk("dp_state", dp_state, to_state(m_st));
        end
        if (done === 1'b1) n_done++;
        if (rk_req === 1'b1 && ack) begin
            n_req_ack++;
            idx_q.push_back(int'(rk_index));
            mode_q.push_back(int'(dp_mode));
        end
        start     = st;
        plaintext = pt;
        rk_ack    = ack;
        rk_data   = (m_busy && ack) ? rks[m_k] : rnd128();
        m_done = 0;
        if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_k = 0; m_st = pt;
                for (int r = 0; r <= NR; r++) rks[r] = rk_of(key, r);
            end
        end else if (ack) begin
            if (m_k < NR) begin
                m_st = m_round(m_st, rks[m_k], (m_k == 0) ? 0 : 1);
                m_k++;
            end else begin
                m_ct = m_round(m_st, rks[NR], 2);
                m_done = 1; m_busy = 0;
            end
        end
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input int maxw,
                             input bit sb, input bit skip_start, input bit chain,
                             input logic [127:0] pt2, input logic [127:0] key2,
                             output logic [127:0] ct, output int lat);
        int  s;
        int  w;
        bit  got;
        bit  a;
        got = 0; ct = '0; lat = -1;
        if (!skip_start) step(1'b1, 1'b0, pt, key);
        s = cyc;
        w = (maxw == 0) ? 0 : int'($urandom_range(0, maxw));
        for (int n = 0; n < 300 && !got; n++) begin
            if (m_done) begin
                step(chain, 1'b0, pt2, key2);
                ct = ciphertext; lat = cyc - s; got = 1;
            end else begin
                a = (w == 0);
                if (a) w = (maxw == 0) ? 0 : int'($urandom_range(0, maxw));
                else w--;
                step(sb, a, rnd128(), rnd128());
            end
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL block_timeout: no done within 300 cycles (cycle %0d)", cyc);
        end
    endtask

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        logic [127:0] ct, ct2, ptr, keyr;
        int lat, d0, a0;
        rst = 1'b1; start = 1'b0; plaintext = '0; rk_ack = 1'b0; rk_data = '0;
        build_sbox();
        model_reset();
        for (int r = 0; r <= NR; r++) rks[r] = '0;
        chk("model_sbox_53", sbox[8'h53], 128'hed);
        chk("model_app_b", aes_enc(PT_B, KEY_B), CT_B);
        chk("model_app_c1", aes_enc(PT_C, KEY_C), CT_C);
        chk("model_rk10_b", rk_of(KEY_B, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rk_req", rk_req, 0);
        chk("reset_rk_index", rk_index, 0);
        chk("reset_ciphertext", ciphertext, 0);
        chk("reset_dp_state", dp_state, 0);
        rst = 1'b0;

        // App. B, zero-wait key schedule
        idx_q.delete(); mode_q.delete(); a0 = n_req_ack;
        run_block(PT_B, KEY_B, 0, 0, 0, 0, '0, '0, ct, lat);
        chk("app_b_ct", ct, CT_B);
        chk("app_b_latency", lat, 12);
        chk("app_b_requests", n_req_ack - a0, 11);
        for (int i = 0; i <= NR; i++) begin
            chk("app_b_index_seq", (i < idx_q.size()) ? idx_q[i] : -1, i);
            chk("app_b_mode_seq", (i < mode_q.size()) ? mode_q[i] : -1, (i == 0) ? 0 : (i == NR) ? 2 : 1);
        end

        // App. C.1 with 0-5 wait cycles per key
        run_block(PT_C, KEY_C, 5, 0, 0, 0, '0, '0, ct, lat);
        chk("app_c1_ct", ct, CT_C);

        // start held high while busy: one block, one done
        d0 = n_done; a0 = n_req_ack;
        run_block(PT_C, KEY_C, 2, 1, 0, 0, '0, '0, ct, lat);
        repeat (20) step(1'b0, 1'b0, rnd128(), rnd128());
        chk("busy_start_dones", n_done - d0, 1);
        chk("busy_start_requests", n_req_ack - a0, 11);

        // start accepted in the done cycle, compared against an independent run
        ptr = rnd128(); keyr = rnd128();
        run_block(PT_B, KEY_B, 1, 0, 0, 1, ptr, keyr, ct, lat);
        chk("chain_first_ct", ct, CT_B);
        run_block(ptr, keyr, 3, 0, 1, 0, '0, '0, ct, lat);
        run_block(ptr, keyr, 0, 0, 0, 0, '0, '0, ct2, lat);
        chk("chain_vs_independent", ct, ct2);
        chk("chain_vs_model", ct, aes_enc(ptr, keyr));

        // random blocks with random waits and start noise
        for (int b = 0; b < 4; b++) begin
            ptr = rnd128(); keyr = rnd128();
            run_block(ptr, keyr, 3, bit'($urandom_range(0, 1)), 0, 0, '0, '0, ct, lat);
            chk("random_block_ct", ct, aes_enc(ptr, keyr));
        end

        // asynchronous reset mid-FETCH at round 5
        step(1'b1, 1'b0, PT_B, KEY_B);
        for (int n = 0; n < 50 && m_k != 5; n++) step(1'b0, 1'b1, rnd128(), rnd128());
        step(1'b0, 1'b0, rnd128(), rnd128());
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rk_req", rk_req, 0);
        chk("async_rst_ciphertext", ciphertext, 0);
        chk("async_rst_rk_index", rk_index, 0);
        start = 1'b0; rk_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_block(PT_B, KEY_B, 0, 0, 0, 0, '0, '0, ct, lat);
        chk("post_rst_app_b_ct", ct, CT_B);
        chk("post_rst_latency", lat, 12);

        // rk_ack in IDLE with start low: nothing moves
        d0 = n_done;
        repeat (100) step(1'b0, 1'b1, rnd128(), rnd128());
        chk("idle_ack_dones", n_done - d0, 0);
        chk("idle_ack_ct_hold", ciphertext, CT_B);
        chk("idle_ack_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption sequencer: owns the 128-bit state register and the round counter.
- Each cycle it drives one shared round datapath, which performs ARK-only, a full round, or the final round. ARK is the xor with the round key re-laid to column-major state order.
- Fetches round keys from the key-schedule block over a req/ack handshake.
- Converts plaintext into state order on load, and the result back to text order on completion.

Parameters:
- NR, 10: number of cipher rounds. Key indices run 0..NR.
- IDX_W, 4: width of the round-key index. Must satisfy 2^IDX_W > NR.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin encryption; sampled only in IDLE
- plaintext  in  128  text order, byte 0 in [127:120]; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start through the cycle of the final ack
- done  out  1  one-cycle pulse; ciphertext is valid from this cycle on
- ciphertext  out  128  text order; held until the next done
- rk_req  out  1  round-key request
- rk_index  out  IDX_W  requested key index; stable while rk_req is high
- rk_ack  in  1  key-schedule acknowledge; rk_data is valid this cycle
- rk_data  in  128  round key in text order; passed unmodified to the datapath
- dp_state  out  128  current state register (state order)
- dp_key  out  128  equals rk_data
- dp_mode  out  2  0 = ARK only; 1 = Sub/Shift/Mix/ARK; 2 = Sub/Shift/ARK; 3 = reserved, never driven
- dp_result  in  128  combinational datapath output (state order)

Behaviour:
- Reset (async, any state): FSM goes to IDLE. round = 0, state_reg = 0, ciphertext = 0, busy = 0, done = 0, rk_req = 0, rk_index = 0.
- FSM states: IDLE, FETCH.
- IDLE:
  - done = 0 except for the registered pulse.
  - On start: state_reg <= text_to_state(plaintext), round <= 0, go to FETCH.
  - busy, rk_req and rk_index are registered and rise in the next cycle.
- FETCH:
  - rk_req = 1, rk_index = round.
  - dp_mode = 0 if round == 0; 2 if round == NR; else 1.
  - On rk_ack, when round < NR: state_reg <= dp_result, round <= round + 1, stay in FETCH.
  - On rk_ack, when round == NR: ciphertext <= state_to_text(dp_result), done <= 1 for the next cycle, busy <= 0, rk_req <= 0, go to IDLE.
  - Without rk_ack: hold state_reg, round and rk_index. There is no timeout.
- Zero-wait key schedule (rk_ack tied high): start at cycle T gives acks at T+1..T+NR+1 and done at T+NR+2. That is 12 cycles start-to-done for NR = 10. Exactly NR+1 requests per block.
- rk_ack is ignored in IDLE. start is ignored while busy, with no queueing. start is accepted in the same cycle done is high, since the FSM is then in IDLE.
- The round counter never exceeds NR and never wraps.
- dp_key, dp_state and dp_mode are driven in every state. In IDLE, dp_mode = 0 and the outputs are don't-care.
- text_to_state transposes the 4x4 byte matrix: state byte 4i+j = text byte 4j+i. state_to_text is the same transpose, since the transpose is self-inverse.

Decomposition:
- Package aes_pkg holds:
  - dp_mode localparams MODE_ARK = 0, MODE_ROUND = 1, MODE_FINAL = 2
  - AES128_NR = 10
  - function text_to_state and its alias state_to_text, shared with the datapath blocks
- No sub-module: the FSM, counter and state register form one module. The round datapath and key schedule are external, and the bench connects existing blocks.

Test Plan:
- FIPS-197 App. B, rk_ack tied high: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> ciphertext 3925841d02dc09fbdc118597196a0b32. Checks:
  - done exactly 12 cycles after start
  - rk_index sequence 0..10
  - dp_mode sequence 0, 1×9, 2
- FIPS-197 App. C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a. rk_ack is random with 0-5 wait cycles; result identical, and rk_index is stable while rk_req is high without ack.
- start pulses on every cycle while busy -> only one done and 11 requests. start in the done cycle -> second block begins, and its ciphertext matches an independent run.
- Assert rst asynchronously mid-FETCH at round 5 -> immediately:
  - busy = 0, rk_req = 0, ciphertext = 0
  - a following App. B run completes correctly
- rk_ack asserted in IDLE, start low -> no state change, busy and done stay 0. ciphertext holds its last value across 100 idle cycles.
